// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core with ECALL halt and retire counter
module multicycle_control_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_source,
  output logic [1:0]  mem_to_reg,
  output logic        is_halted,
  output logic [2:0]  state,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
    OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_ECALL = 7'b1110011;
  state_t cur, nxt;
  logic retire, is_load;
  assign state = cur;
  assign is_load = opcode == OP_LOAD;
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    i_or_d = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_source = 1'b0;
    mem_to_reg = 2'b00;
    is_halted = 1'b0;
    nxt = cur;
    case (cur)
      S_IF: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        nxt = opcode == OP_ECALL ? (halt_req ? S_HALT : S_IF) :
              opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR} ? S_EX : S_IF;
      end
      S_EX: begin
        nxt = S_IF;
        case (opcode)
          OP_R: begin
            alu_src_a = 2'b10;
            alu_op = 2'b10;
            nxt = S_WB;
          end
          OP_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            alu_op = 2'b10;
            nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            nxt = S_MEM;
          end
          OP_BR: begin
            alu_src_a = 2'b10;
            alu_op = 2'b01;
            pc_write_cond = 1'b1;
            pc_source = 1'b1;
          end
          // target of JAL was computed into ALUOut during ID
          OP_JAL: begin
            pc_write = 1'b1;
            pc_source = 1'b1;
            reg_write = 1'b1;
            mem_to_reg = 2'b10;
          end
          OP_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            pc_write = 1'b1;
            reg_write = 1'b1;
            mem_to_reg = 2'b10;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        mem_read = is_load;
        mem_write = opcode == OP_STORE;
        nxt = !mem_ready ? S_MEM : is_load ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_to_reg = is_load ? 2'b01 : 2'b00;
        nxt = S_IF;
      end
      S_HALT: is_halted = 1'b1;
      default: nxt = S_IF;
    endcase
    retire = nxt == S_IF && cur != S_IF;
    // outputs are forced quiet for the whole reset pulse, not just after the edge
    if (!reset_n) begin
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      i_or_d = 1'b0;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_op = 2'b00;
      pc_source = 1'b0;
      mem_to_reg = 2'b00;
      is_halted = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur <= S_IF;
      instret <= '0;
    end else begin
      cur <= nxt;
      instret <= instret + {31'b0, retire};
    end
endmodule
